// File: rtl/power_spectrum_framer.sv
// power_spectrum_framer
//   Producer side of the power_spectrum/power_valid interface consumed by
//   mel_filterbank. Streams complex FFT bins in, computes re^2 + im^2, then
//   right-shifts by SCALE_SHIFT and saturates to the positive signed range.
//   Each FFT_SIZE frame is assembled in a ping-pong buffer and published with
//   a single-cycle power_valid_o pulse.
//
//   Pipeline: bin accepted at E0, squares registered at E1, the
//   sum/shift/saturate result is written to the active bank at E2.
//
// Ports
//   clk_i             clock, rising edge
//   rst_i             synchronous reset, active-high
//   fft_re_i/fft_im_i signed real/imaginary part of the current bin
//   fft_valid_i       bin present (accepted when fft_valid_i && fft_ready_o)
//   fft_last_i        final bin of the frame, qualified by fft_valid_i
//   fft_ready_o       0 while rst_i is high, else 1
//   power_spectrum_o  [0:FFT_SIZE-1] words of the last completed frame
//   power_valid_o     1-cycle pulse: new frame on power_spectrum_o
//   frame_err_o       1-cycle pulse: short or long frame, frame dropped
//   frame_energy_o    (POWER_SPEC_ENERGY_EN only) sum of the published words
//
// Build option: define POWER_SPEC_ENERGY_EN to add frame_energy_o and its
// accumulator. Without it, neither exists.
//
// state   | meaning
// --------+-----------------------------------------------------------
// COLLECT | accepting bins of a frame, bin_cnt_q = write address
// DISCARD | long frame detected; dropping bins until fft_last_i

module power_spectrum_framer #(
    parameter int DATA_WIDTH  = 16,
    parameter int FFT_SIZE    = 256,
    parameter int SCALE_SHIFT = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] fft_re_i,
    input  logic [DATA_WIDTH-1:0] fft_im_i,
    input  logic                  fft_valid_i,
    input  logic                  fft_last_i,
    output logic                  fft_ready_o,
    output logic [DATA_WIDTH-1:0] power_spectrum_o [0:FFT_SIZE-1],
    output logic                  power_valid_o,
`ifdef POWER_SPEC_ENERGY_EN
    output logic [DATA_WIDTH+$clog2(FFT_SIZE)-1:0] frame_energy_o,
`endif
    output logic                  frame_err_o
);

    localparam int CNT_W = $clog2(FFT_SIZE);
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int SUM_W = PW + 1;
    localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(FFT_SIZE - 1);
    localparam logic [SUM_W-1:0] SAT_MAX  =
        {{(DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};

    typedef enum logic {COLLECT, DISCARD} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bin_cnt_q, bin_cnt_d;
    logic               accept;
    logic               s0_vld_d, s0_done_d, s0_err_d;

    logic                         s0_vld_q, s0_done_q, s0_err_q;
    logic [CNT_W-1:0]             s0_addr_q;
    logic signed [DATA_WIDTH-1:0] s0_re_q, s0_im_q;

    logic                         s1_vld_q, s1_done_q, s1_err_q;
    logic [CNT_W-1:0]             s1_addr_q;
    logic [PW-1:0]                s1_sq_re_q, s1_sq_im_q;

    logic signed [PW-1:0]         prod_re, prod_im;
    logic [SUM_W-1:0]             sum, shifted;
    logic [DATA_WIDTH-1:0]        word;

    logic [DATA_WIDTH-1:0] bank_q [0:1][0:FFT_SIZE-1];
    logic                  wr_bank_q;
    logic                  rd_bank;
    logic                  power_valid_q, frame_err_q;

    assign fft_ready_o = ~rst_i;
    assign accept      = fft_valid_i && fft_ready_o;

    // ---------------- framing FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= COLLECT;
            bin_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bin_cnt_q <= bin_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bin_cnt_d = bin_cnt_q;
        s0_vld_d  = 1'b0;
        s0_done_d = 1'b0;
        s0_err_d  = 1'b0;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    s0_vld_d = 1'b1;
                    if (fft_last_i) begin
                        bin_cnt_d = '0;
                        if (bin_cnt_q == LAST_BIN) s0_done_d = 1'b1;
                        else                       s0_err_d  = 1'b1;
                    end else if (bin_cnt_q == LAST_BIN) begin
                        bin_cnt_d = '0;
                        s0_err_d  = 1'b1;
                        state_d   = DISCARD;
                    end else begin
                        bin_cnt_d = bin_cnt_q + CNT_W'(1);
                    end
                end
            end
            DISCARD: begin
                if (accept && fft_last_i) begin
                    state_d   = COLLECT;
                    bin_cnt_d = '0;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // ---------------- arithmetic pipeline ----------------
    // Operands are sign-extended before multiplying; the square of the most
    // negative input is 2^(2*DATA_WIDTH-2), which still fits as unsigned.
    assign prod_re = PW'(s0_re_q) * PW'(s0_re_q);
    assign prod_im = PW'(s0_im_q) * PW'(s0_im_q);

    assign sum     = SUM_W'(s1_sq_re_q) + SUM_W'(s1_sq_im_q);
    assign shifted = sum >> SCALE_SHIFT;
    assign word    = (shifted > SAT_MAX) ? SAT_MAX[DATA_WIDTH-1:0]
                                         : shifted[DATA_WIDTH-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s0_vld_q      <= 1'b0;
            s0_done_q     <= 1'b0;
            s0_err_q      <= 1'b0;
            s0_addr_q     <= '0;
            s0_re_q       <= '0;
            s0_im_q       <= '0;
            s1_vld_q      <= 1'b0;
            s1_done_q     <= 1'b0;
            s1_err_q      <= 1'b0;
            s1_addr_q     <= '0;
            s1_sq_re_q    <= '0;
            s1_sq_im_q    <= '0;
            frame_err_q   <= 1'b0;
            power_valid_q <= 1'b0;
            wr_bank_q     <= 1'b0;
        end else begin
            s0_vld_q      <= s0_vld_d;
            s0_done_q     <= s0_done_d;
            s0_err_q      <= s0_err_d;
            s0_addr_q     <= bin_cnt_q;
            s0_re_q       <= fft_re_i;
            s0_im_q       <= fft_im_i;
            s1_vld_q      <= s0_vld_q;
            s1_done_q     <= s0_done_q;
            s1_err_q      <= s0_err_q;
            s1_addr_q     <= s0_addr_q;
            s1_sq_re_q    <= prod_re;
            s1_sq_im_q    <= prod_im;
            frame_err_q   <= s0_err_d;
            power_valid_q <= s1_vld_q && s1_done_q;
            // The last bin's write still targets the old bank; the toggle
            // takes effect for the next frame's first write at E3.
            if (s1_vld_q && s1_done_q) wr_bank_q <= ~wr_bank_q;
        end
    end

    // ---------------- ping-pong storage ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < FFT_SIZE; i++)
                    bank_q[b][i] <= '0;
        end else if (s1_vld_q) begin
            bank_q[wr_bank_q][s1_addr_q] <= word;
        end
    end

    assign rd_bank = ~wr_bank_q;

    always_comb begin
        for (int i = 0; i < FFT_SIZE; i++)
            power_spectrum_o[i] = bank_q[rd_bank][i];
    end

    assign power_valid_o = power_valid_q;
    assign frame_err_o   = frame_err_q;

`ifdef POWER_SPEC_ENERGY_EN
    localparam int EW = DATA_WIDTH + CNT_W;

    logic [EW-1:0] acc_q, energy_q, acc_sum;

    assign acc_sum = acc_q + EW'(word);

    // The clear on error is aligned to the offending bin's E2 so that
    // in-flight bins of the dropped frame never leak into the next total.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            energy_q <= '0;
        end else if (s1_vld_q) begin
            if (s1_done_q) begin
                energy_q <= acc_sum;
                acc_q    <= '0;
            end else if (s1_err_q) begin
                acc_q    <= '0;
            end else begin
                acc_q    <= acc_sum;
            end
        end
    end

    assign frame_energy_o = energy_q;
`endif

endmodule
